// File: rtl/uart_tx_buffer.sv
`default_nettype none
// ============================================================================
// uart_tx_buffer : circular byte FIFO feeding an 8N1 serial transmitter
// Revision 1.0
// ============================================================================
module uart_tx_buffer #(
   parameter int DEPTH_LOG2   = 4,
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [7:0]          dataIn,
   input  logic                writeFlag,
   output logic                tx,
   output logic                full,
   output logic                empty,
   output logic                busy,
   output logic                overflow,
   output logic [DEPTH_LOG2:0] count
);

   localparam int c_depth  = 1 << DEPTH_LOG2;
   localparam int c_baud_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [DEPTH_LOG2:0] c_full_count = (DEPTH_LOG2 + 1)'(c_depth);
   localparam logic [c_baud_w-1:0] c_baud_last  = c_baud_w'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   logic [7:0]            mem_q [c_depth];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  overflow_q, overflow_d;
   state_t                state_q, state_d;
   logic [7:0]            shift_q, shift_d;
   logic [c_baud_w-1:0]   baud_q, baud_d;
   logic [2:0]            bit_q, bit_d;
   logic                  tx_q, tx_d;

   logic w_full, w_empty, w_wr_en, w_pop, w_baud_done;

   assign w_full      = (count_q == c_full_count);
   assign w_empty     = (count_q == '0);
   assign w_wr_en     = writeFlag && !w_full;
   assign w_pop       = (state_q == IDLE) && !w_empty;
   assign w_baud_done = (baud_q == c_baud_last);

   always_comb begin : fifo_next
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (writeFlag & w_full);
      if (w_wr_en) begin
         wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      end
      case ({w_wr_en, w_pop})
         2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
         2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // tx_d is the line level for the next cycle, so tx comes straight off a flop
   always_comb begin : fsm_next
      state_d = state_q;
      shift_d = shift_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (w_pop) begin
               shift_d = mem_q[rd_ptr_q];
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (w_baud_done) begin
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = shift_q[0];
               state_d = DATA;
            end else begin
               baud_d = baud_q + c_baud_w'(1);
            end
         end
         DATA: begin
            if (w_baud_done) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  tx_d = shift_q[1];
               end
            end else begin
               baud_d = baud_q + c_baud_w'(1);
            end
         end
         STOP: begin
            if (w_baud_done) begin
               baud_d  = '0;
               tx_d    = 1'b1;
               state_d = IDLE;
            end else begin
               baud_d = baud_q + c_baud_w'(1);
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         state_q    <= IDLE;
         shift_q    <= '0;
         baud_q     <= '0;
         bit_q      <= '0;
         tx_q       <= 1'b1;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
         shift_q    <= shift_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         tx_q       <= tx_d;
      end
   end

   always_ff @(posedge clock) begin
      if (reset && w_wr_en) begin
         mem_q[wr_ptr_q] <= dataIn;
      end
   end

   assign tx       = tx_q;
   assign full     = w_full;
   assign empty    = w_empty;
   assign busy     = (state_q != IDLE);
   assign overflow = overflow_q;
   assign count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffer.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_buffer : directed stimulus; a serial-line monitor decodes frames
// and scores them against the queue of bytes expected on the wire.
// Revision 1.0
// ============================================================================
module tb_uart_tx_buffer;

   localparam int CPB = 4;
   localparam int DL2 = 2;

   logic           clock     = 1'b0;
   logic           reset     = 1'b0;
   logic           writeFlag = 1'b0;
   logic [7:0]     dataIn    = 8'h00;
   logic           tx, full, empty, busy, overflow;
   logic [DL2:0]   count;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   int frames_rx = 0;
   int neg_cnt   = 0;
   int frame_start_at[64];
   int frame_end_at[64];
   int frame_gap[64];

   int         m_state  = 0;
   int         m_cnt    = 0;
   int         m_bit    = 0;
   int         idle_run = 0;
   logic       m_val    = 1'b1;
   logic [7:0] m_byte   = 8'h00;

   always #5 clock = ~clock;

   uart_tx_buffer #(
      .DEPTH_LOG2   (DL2),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .dataIn    (dataIn),
      .writeFlag (writeFlag),
      .tx        (tx),
      .full      (full),
      .empty     (empty),
      .busy      (busy),
      .overflow  (overflow),
      .count     (count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Serial receiver: one sample per clock on the falling edge, CPB samples per bit.
   always @(negedge clock) begin
      neg_cnt++;
      if (!reset) begin
         m_state  = 0;
         m_cnt    = 0;
         idle_run = 0;
      end else begin
         case (m_state)
            0: begin
               if (tx === 1'b0) begin
                  if (frames_rx < 64) begin
                     frame_start_at[frames_rx] = neg_cnt;
                     frame_gap[frames_rx]      = idle_run;
                  end
                  m_state = 1;
                  m_cnt   = 1;
               end else begin
                  idle_run++;
               end
            end
            1: begin
               chk("start_bit", {31'd0, tx}, 32'd0);
               m_cnt++;
               if (m_cnt == CPB) begin
                  m_state = 2;
                  m_cnt   = 0;
                  m_bit   = 0;
               end
            end
            2: begin
               if (m_cnt == 0) m_val = tx;
               else            chk("data_bit_hold", {31'd0, tx}, {31'd0, m_val});
               m_cnt++;
               if (m_cnt == CPB) begin
                  m_byte = {m_val, m_byte[7:1]};
                  m_cnt  = 0;
                  m_bit++;
                  if (m_bit == 8) m_state = 3;
               end
            end
            default: begin
               chk("stop_bit", {31'd0, tx}, 32'd1);
               m_cnt++;
               if (m_cnt == CPB) begin
                  if (exp_q.size() == 0) begin
                     chk("unexpected_frame", {24'd0, m_byte}, 32'hFFFF_FFFF);
                  end else begin
                     chk("frame_byte", {24'd0, m_byte}, {24'd0, exp_q.pop_front()});
                  end
                  if (frames_rx < 64) frame_end_at[frames_rx] = neg_cnt;
                  frames_rx++;
                  idle_run = 0;
                  m_cnt    = 0;
                  m_state  = 0;
               end
            end
         endcase
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      exp_q.delete();
      writeFlag = 1'b0;
      reset     = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   // expect_tx: byte is expected to appear on the serial line
   task automatic wr(input logic [7:0] b, input bit expect_tx);
      dataIn    = b;
      writeFlag = 1'b1;
      if (expect_tx) exp_q.push_back(b);
      tick();
      writeFlag = 1'b0;
   endtask

   task automatic wait_frames(input int n, input int budget);
      int k = 0;
      while (frames_rx < n && k < budget) begin
         tick();
         k++;
      end
      chk("frame_wait", frames_rx, n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      logic [7:0] b;

      // 1: reset state and single byte 0x73
      do_reset();
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_empty", {31'd0, empty}, 32'd1);
      chk("rst_full", {31'd0, full}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      chk("rst_count", {29'd0, count}, 32'd0);
      base = frames_rx;
      wr(8'h73, 1'b1);
      chk("t1_count_after_write", {29'd0, count}, 32'd1);
      chk("t1_busy_after_write", {31'd0, busy}, 32'd0);
      tick();
      chk("t1_empty_after_pop", {31'd0, empty}, 32'd1);
      chk("t1_busy_after_pop", {31'd0, busy}, 32'd1);
      chk("t1_tx_start", {31'd0, tx}, 32'd0);
      wait_frames(base + 1, 100);
      chk("t1_busy_end", {31'd0, busy}, 32'd0);
      chk("t1_tx_end", {31'd0, tx}, 32'd1);

      // 2: three consecutive writes, back-to-back frames
      idle(5);
      base = frames_rx;
      wr(8'h41, 1'b1);
      chk("t2_count_1", {29'd0, count}, 32'd1);
      wr(8'h42, 1'b1);
      chk("t2_count_2", {29'd0, count}, 32'd1);
      wr(8'h43, 1'b1);
      chk("t2_count_peak", {29'd0, count}, 32'd2);
      wait_frames(base + 3, 300);
      chk("t2_gap_1", frame_gap[base + 1], 32'd1);
      chk("t2_gap_2", frame_gap[base + 2], 32'd1);
      chk("t2_span", frame_end_at[base + 2] - frame_start_at[base] + 1, 32'd122);

      // 3: burst of five during a frame, fifth dropped
      idle(5);
      base = frames_rx;
      wr(8'h10, 1'b1);
      idle(3);
      wr(8'h11, 1'b1);
      wr(8'h12, 1'b1);
      wr(8'h13, 1'b1);
      wr(8'h14, 1'b1);
      chk("t3_count_full", {29'd0, count}, 32'd4);
      chk("t3_full", {31'd0, full}, 32'd1);
      chk("t3_overflow_before", {31'd0, overflow}, 32'd0);
      wr(8'h15, 1'b0);
      chk("t3_count_after_drop", {29'd0, count}, 32'd4);
      chk("t3_overflow_set", {31'd0, overflow}, 32'd1);
      wait_frames(base + 5, 400);
      chk("t3_overflow_sticky", {31'd0, overflow}, 32'd1);
      idle(60);
      chk("t3_no_extra_frame", frames_rx, base + 5);
      chk("t3_empty", {31'd0, empty}, 32'd1);

      // 4: write while full in the same cycle as a pop
      do_reset();
      chk("t4_overflow_clear", {31'd0, overflow}, 32'd0);
      base = frames_rx;
      wr(8'h20, 1'b1);
      wr(8'h21, 1'b1);
      wr(8'h22, 1'b1);
      wr(8'h23, 1'b1);
      wr(8'h24, 1'b1);
      chk("t4_full", {31'd0, full}, 32'd1);
      wait_frames(base + 1, 100);
      chk("t4_idle_before_pop", {31'd0, busy}, 32'd0);
      chk("t4_count_before_pop", {29'd0, count}, 32'd4);
      wr(8'h25, 1'b0);
      chk("t4_count_after_pop", {29'd0, count}, 32'd3);
      chk("t4_overflow", {31'd0, overflow}, 32'd1);
      chk("t4_busy", {31'd0, busy}, 32'd1);
      wait_frames(base + 5, 400);

      // 5: reset mid-DATA with bytes queued
      idle(5);
      base = frames_rx;
      wr(8'h30, 1'b0);
      wr(8'h31, 1'b0);
      wr(8'h32, 1'b0);
      idle(8);
      chk("t5_busy_mid", {31'd0, busy}, 32'd1);
      exp_q.delete();
      reset = 1'b0;
      tick();
      chk("t5_tx", {31'd0, tx}, 32'd1);
      chk("t5_busy", {31'd0, busy}, 32'd0);
      chk("t5_empty", {31'd0, empty}, 32'd1);
      chk("t5_count", {29'd0, count}, 32'd0);
      chk("t5_overflow", {31'd0, overflow}, 32'd0);
      reset = 1'b1;
      idle(100);
      chk("t5_no_frames", frames_rx, base);
      chk("t5_tx_idle", {31'd0, tx}, 32'd1);

      // 6: fill and drain three times across pointer wrap
      for (int it = 0; it < 3; it++) begin
         base = frames_rx;
         for (int k = 0; k < 5; k++) begin
            b = 8'(8'h60 + it * 16 + k);
            wr(b, 1'b1);
         end
         chk("t6_full", {31'd0, full}, 32'd1);
         chk("t6_count_full", {29'd0, count}, 32'd4);
         wait_frames(base + 5, 400);
         chk("t6_empty", {31'd0, empty}, 32'd1);
         chk("t6_not_full", {31'd0, full}, 32'd0);
         chk("t6_overflow", {31'd0, overflow}, 32'd0);
         idle(3);
      end

      chk("leftover_expected", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Transmit-side buffer and serializer downstream of the debug unit.
- Accepts bytes written through the debug unit's outgoing FIFO interface (dataToUartOutFifo / writeFifoFlag).
- Queues the bytes in a circular FIFO and shifts each one out on the serial TX line as an 8N1 frame.
- Bridges the debug unit's single-cycle burst writes to the slow UART line rate.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (depth = 2^DEPTH_LOG2 = 16 entries).
- CLKS_PER_BIT, 5208, clock cycles per serial bit (50 MHz / 9600 baud).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low; sampled on the rising edge of clock.
- dataIn  in  8  byte to enqueue; driven from debug unit dataToUartOutFifo.
- writeFlag  in  1  enqueue strobe, one byte per high cycle; from debug unit writeFifoFlag.
- tx  out  1  serial line, idles high.
- full  out  1  count == 2^DEPTH_LOG2.
- empty  out  1  count == 0.
- busy  out  1  serializer not in IDLE.
- overflow  out  1  sticky; set when a write arrives while full.
- count  out  DEPTH_LOG2+1  current FIFO occupancy.

Behaviour:
- Reset (reset==0 at an edge):
  - wrPtr=rdPtr=count=0, state=IDLE, tx=1, overflow=0, bit counters 0.
  - Outputs after the edge: empty=1, full=0, busy=0.
  - Reset mid-frame aborts the frame; tx returns high right after the reset edge; queued bytes are discarded.
- FIFO:
  - Pointers are DEPTH_LOG2 bits and wrap modulo depth.
  - count is tracked separately to distinguish full from empty.
  - Write is accepted iff writeFlag==1 and count<depth, both sampled before the edge. mem[wrPtr]<=dataIn; wrPtr++.
  - Write while full: byte dropped, pointers unchanged, overflow<=1, which holds until reset.
  - Pop (serializer load) is allowed only when count>0 before the edge.
  - Simultaneous accepted write and pop: count unchanged.
  - Write while full plus a pop in the same cycle: the write is still rejected.
- full, empty and count are registered-state derived and reflect the post-edge occupancy.
- Serializer FSM: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If empty==0 at an edge: shiftReg<=mem[rdPtr], rdPtr++, count--, baudCnt<=0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bitIdx=0.
  - DATA: tx=shiftReg[0] for CLKS_PER_BIT cycles per bit, LSB first. After each bit: shift right, bitIdx++. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- tx is driven from a register; no combinational glitches.
- Timing:
  - Byte written at edge N into an empty FIFO, serializer idle: pop at edge N+1; tx low from after N+1.
  - Frame occupies exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back bytes: exactly one IDLE cycle (tx=1) between the STOP end and the next START.
- baudCnt counts 0..CLKS_PER_BIT-1 and needs ceil(log2(CLKS_PER_BIT)) bits.
- busy=1 in START/DATA/STOP.

Test Plan (CLKS_PER_BIT=4, DEPTH_LOG2=2):
1. Reset, then a single write of 0x73 ('s') -> next edge empty=1 and busy=1. tx sequence, 4 cycles each: 0, 1,1,0,0,1,1,1,0, 1. Then busy=0 and tx=1.
2. Write 0x41, 0x42, 0x43 on consecutive cycles -> count peaks at 2 (first byte already popped). Three frames go out in order, separated by exactly one idle-high cycle. Total 3*40+2 cycles from the first tx fall to the last stop end.
3. During a frame, write 5 bytes back-to-back -> count reaches 4 and full=1. The 5th write is dropped and overflow=1. Exactly 5 frames total are sent (1 in flight + 4 queued), and overflow stays 1.
4. Full FIFO, write asserted in the same cycle the serializer pops -> write rejected, count goes 4->3, overflow=1.
5. Reset pulsed low mid-DATA with 2 bytes queued -> after the edge tx=1, busy=0, empty=1, count=0, overflow=0. No further frames.
6. Fill to depth 4, then drain completely; repeat 3 times (pointer wrap) -> byte order is preserved across wrap, and full/empty toggle at count 4/0.
